score_keeper: RTL



---
 rtl/score_keeper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - table-tennis game score engine driving two 4-bit display codes
// Optional feature macro: SCORE_DEUCE_EN (win-by-two via DEUCE/ADV_A/ADV_B states)
module score_keeper #(
   parameter int START_SERVER = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pt_a,
   input  logic       pt_b,
   input  logic       new_game,
   output logic [3:0] score_a,
   output logic [3:0] score_b,
   output logic       server,
   output logic       game_over,
   output logic       winner
);

   localparam logic START_BIT = (START_SERVER != 0);

`ifdef SCORE_DEUCE_EN
   typedef enum logic [2:0] {
      PLAY  = 3'd0,
      WON_A = 3'd1,
      WON_B = 3'd2,
      DEUCE = 3'd3,
      ADV_A = 3'd4,
      ADV_B = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      PLAY  = 3'd0,
      WON_A = 3'd1,
      WON_B = 3'd2
   } state_t;
`endif

   state_t     state, state_n;
   logic [3:0] score_a_n, score_b_n;
   logic       server_n;
   logic       pair, pair_n;
   logic       pt_a_q, pt_b_q;
   logic       hit_a, hit_b;

   assign hit_a = pt_a & ~pt_a_q;
   assign hit_b = pt_b & ~pt_b_q;

   // State, score, serve and edge-detect registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= PLAY;
         score_a <= 4'd0;
         score_b <= 4'd0;
         server  <= START_BIT;
         pair    <= 1'b0;
         pt_a_q  <= 1'b0;
         pt_b_q  <= 1'b0;
      end else begin
         state   <= state_n;
         score_a <= score_a_n;
         score_b <= score_b_n;
         server  <= server_n;
         pair    <= pair_n;
         pt_a_q  <= pt_a;
         pt_b_q  <= pt_b;
      end
   end

   // Next-state and next-score logic; a lone hit is the only thing that moves the game
   always_comb begin
      state_n   = state;
      score_a_n = score_a;
      score_b_n = score_b;
      server_n  = server;
      pair_n    = pair;
      if (new_game) begin
         state_n   = PLAY;
         score_a_n = 4'd0;
         score_b_n = 4'd0;
         server_n  = START_BIT;
         pair_n    = 1'b0;
      end else if (hit_a ^ hit_b) begin
         case (state)
            PLAY: begin
               if (hit_a) score_a_n = score_a + 4'd1;
               else       score_b_n = score_b + 4'd1;
               pair_n = ~pair;
               if (pair) server_n = ~server;
               // With deuce built, 11 can only be reached here against <= 9
               if (score_a_n == 4'd11)      state_n = WON_A;
               else if (score_b_n == 4'd11) state_n = WON_B;
`ifdef SCORE_DEUCE_EN
               else if (score_a_n == 4'd10 && score_b_n == 4'd10) state_n = DEUCE;
`endif
            end
`ifdef SCORE_DEUCE_EN
            DEUCE: begin
               server_n = ~server;
               pair_n   = 1'b0;
               if (hit_a) begin
                  state_n   = ADV_A;
                  score_a_n = 4'd11;
               end else begin
                  state_n   = ADV_B;
                  score_b_n = 4'd11;
               end
            end
            ADV_A: begin
               server_n = ~server;
               pair_n   = 1'b0;
               if (hit_a) begin
                  state_n = WON_A;
               end else begin
                  state_n   = DEUCE;
                  score_a_n = 4'd10;
               end
            end
            ADV_B: begin
               server_n = ~server;
               pair_n   = 1'b0;
               if (hit_b) begin
                  state_n = WON_B;
               end else begin
                  state_n   = DEUCE;
                  score_b_n = 4'd10;
               end
            end
`endif
            default: begin
               state_n = state;
            end
         endcase
      end
   end

   assign game_over = (state == WON_A) || (state == WON_B);
   assign winner    = (state == WON_B);

endmodule
